// File: rtl/cpu_state_seq_pkg.sv
// Shared architectural register layout of the TD4 core, used by the
// state sequencer and by the ALU that computes its successor.
package cpu_state_seq_pkg;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] out;
        logic [3:0] pc;
        logic       carry;
    } regs_t;

endpackage

// File: rtl/cpu_state_seq.sv
// TD4 architectural state holder and sequencer: holds committed REGS, decodes the
// fetched ROM word, and commits the ALU's successor state on a tick or a single step.
module cpu_state_seq
    import cpu_state_seq_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int CNT_W       = 16,
    parameter int HALT_DETECT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step_req,
    output logic [3:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic [3:0]       opecode,
    output logic [3:0]       imm,
    output regs_t            current,
    input  regs_t            next,
    output logic [3:0]       out_port,
    output logic             commit,
    output logic             halted,
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [15:0]      DIV_LAST = 16'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [15:0] pcnt;
    logic        step_prev;
    logic        tick;
    logic        step_edge;
    logic        do_commit;
    logic        self_loop;

    // Fetch/decode is purely combinational: one commit retires one instruction.
    assign rom_addr = current.pc;
    assign opecode  = rom_data[7:4];
    assign imm      = rom_data[3:0];
    assign out_port = current.out;

    assign tick      = (pcnt == DIV_LAST) && run;
    assign step_edge = step_req && !step_prev && !run;
    assign do_commit = (tick || step_edge) && !halted;
    assign self_loop = (HALT_DETECT != 0) && (next == current);

    // commit is a registered pulse: high for exactly the one cycle after
    // the clock edge at which current/inst_count were updated.
    always_ff @(posedge clk) begin
        if (rst) begin
            current    <= '0;
            pcnt       <= '0;
            step_prev  <= 1'b0;
            commit     <= 1'b0;
            halted     <= 1'b0;
            inst_count <= '0;
        end else begin
            step_prev <= step_req;
            commit    <= do_commit;

            if (!run || (pcnt == DIV_LAST)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end

            if (do_commit) begin
                current <= next;
                if (inst_count != CNT_MAX) begin
                    inst_count <= inst_count + 1'b1;
                end
                if (self_loop) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_state_seq.sv
// Bench for cpu_state_seq: a small TD4 ALU model closes the loop, directed
// vectors push hand-computed states into a queue that a commit monitor drains.
module tb_cpu_state_seq;
    import cpu_state_seq_pkg::*;

    localparam int EW = 33;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic run;
    logic step_req;
    logic run_sat;

    // ---------------- main DUT (DIV=4, CNT_W=16) ----------------
    logic [3:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  opecode;
    logic [3:0]  imm;
    regs_t       current;
    regs_t       next;
    logic [3:0]  out_port;
    logic        commit;
    logic        halted;
    logic [15:0] inst_count;

    // ---------------- saturation DUT (DIV=1, CNT_W=2, no halt) ----------------
    logic [3:0]  rom_addr_sat;
    logic [7:0]  rom_data_sat;
    logic [3:0]  opecode_sat;
    logic [3:0]  imm_sat;
    regs_t       current_sat;
    regs_t       next_sat;
    logic [3:0]  out_port_sat;
    logic        commit_sat;
    logic        halted_sat;
    logic [1:0]  inst_count_sat;

    logic [7:0] rom [16];

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    cpu_state_seq #(.DIV(4), .CNT_W(16), .HALT_DETECT(1)) u_dut (
        .clk(clk), .rst(rst), .run(run), .step_req(step_req),
        .rom_addr(rom_addr), .rom_data(rom_data), .opecode(opecode), .imm(imm),
        .current(current), .next(next), .out_port(out_port),
        .commit(commit), .halted(halted), .inst_count(inst_count)
    );

    cpu_state_seq #(.DIV(1), .CNT_W(2), .HALT_DETECT(0)) u_sat (
        .clk(clk), .rst(rst), .run(run_sat), .step_req(1'b0),
        .rom_addr(rom_addr_sat), .rom_data(rom_data_sat), .opecode(opecode_sat), .imm(imm_sat),
        .current(current_sat), .next(next_sat), .out_port(out_port_sat),
        .commit(commit_sat), .halted(halted_sat), .inst_count(inst_count_sat)
    );

    // Minimal TD4 ALU: ADD A,im / MOV A,im / MOV B,im / OUT im / JMP im; rest is nop.
    function automatic regs_t alu(input regs_t c, input logic [3:0] op, input logic [3:0] im);
        regs_t      n;
        logic [4:0] s;
        n       = c;
        n.pc    = c.pc + 4'd1;
        n.carry = 1'b0;
        s       = {1'b0, c.a} + {1'b0, im};
        case (op)
            4'h0: begin n.a = s[3:0]; n.carry = s[4]; end
            4'h3: n.a = im;
            4'h7: n.b = im;
            4'hB: n.out = im;
            4'hF: n.pc = im;
            default: ;
        endcase
        return n;
    endfunction

    assign rom_data     = rom[rom_addr];
    assign rom_data_sat = (rom_addr_sat == 4'd5) ? 8'hF5 : 8'h00;
    always_comb next     = alu(current, opecode, imm);
    always_comb next_sat = alu(current_sat, opecode_sat, imm_sat);

    function automatic logic [EW-1:0] ew(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] o, input logic [3:0] pc,
                                         input logic c, input logic [15:0] n);
        return {a, b, o, pc, c, n};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit got=%0h exp=none", {current, inst_count});
            end else begin
                e = exp_q.pop_front();
                check("commit_state", 64'({current, inst_count}), 64'(e));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h35;  // MOV A,5
        rom[1] = 8'h72;  // MOV B,2
        rom[2] = 8'h03;  // ADD A,3
        rom[3] = 8'hF3;  // JMP 3 (self loop)
        rst = 1'b1; run = 1'b0; step_req = 1'b0; run_sat = 1'b0;

        // Reset held two cycles.
        cycles(2);
        check("rst_current",    64'(current), 64'(0));
        check("rst_rom_addr",   64'(rom_addr), 64'(0));
        check("rst_halted",     64'(halted), 64'(0));
        check("rst_inst_count", 64'(inst_count), 64'(0));
        check("rst_commit",     64'(commit), 64'(0));
        check("rst_decode",     64'({opecode, imm}), 64'(8'h35));
        rst = 1'b0;

        // Run mode: first commit on the 4th edge, then every 4 edges.
        exp_q.push_back(ew(4'd5, 4'd0, 4'd0, 4'd1, 1'b0, 16'd1));
        exp_q.push_back(ew(4'd5, 4'd2, 4'd0, 4'd2, 1'b0, 16'd2));
        run = 1'b1;
        cycles(3);
        check("run_before_tick", 64'({current.pc, inst_count}), 64'({4'd0, 16'd0}));
        cycles(1);
        check("run_first_commit", 64'(commit), 64'(1));
        cycles(3);
        check("run_gap", 64'({commit, inst_count}), 64'({1'b0, 16'd1}));
        cycles(1);
        check("run_second_commit", 64'(inst_count), 64'(2));
        run = 1'b0;
        cycles(6);
        check("run_off_hold", 64'(inst_count), 64'(2));
        check("run_queue_drained", 64'(exp_q.size()), 64'(0));

        // Step mode: a held level gives one step; re-raise gives another.
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        exp_q.push_back(ew(4'd5, 4'd0, 4'd0, 4'd1, 1'b0, 16'd1));
        step_req = 1'b1;
        cycles(10);
        step_req = 1'b0;
        cycles(2);
        check("step_held_once", 64'(inst_count), 64'(1));
        exp_q.push_back(ew(4'd5, 4'd2, 4'd0, 4'd2, 1'b0, 16'd2));
        step_req = 1'b1;
        cycles(2);
        step_req = 1'b0;
        cycles(2);
        check("step_reraise", 64'(inst_count), 64'(2));

        // Step pulses during run are ignored; two ticks run ADD then JMP-to-self.
        exp_q.push_back(ew(4'd8, 4'd2, 4'd0, 4'd3, 1'b0, 16'd3));
        exp_q.push_back(ew(4'd8, 4'd2, 4'd0, 4'd3, 1'b0, 16'd4));
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_req = (i % 2 == 1);
            cycles(1);
        end
        check("halt_set", 64'({halted, inst_count}), 64'({1'b1, 16'd4}));
        step_req = 1'b0;
        cycles(8);
        check("halt_run_frozen", 64'({current, inst_count}),
              64'(ew(4'd8, 4'd2, 4'd0, 4'd3, 1'b0, 16'd4)));
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step_req = (i % 2 == 0);
            cycles(2);
        end
        check("halt_step_frozen", 64'({current, inst_count}),
              64'(ew(4'd8, 4'd2, 4'd0, 4'd3, 1'b0, 16'd4)));
        check("halt_decode", 64'({rom_addr, opecode, imm, out_port}), 64'(16'h3F30));
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("halt_cleared", 64'({halted, current, inst_count}), 64'(0));
        check("step_queue_drained", 64'(exp_q.size()), 64'(0));

        // Reset at pcnt=2 discards the partial prescale count.
        run = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midrst_state", 64'({current, inst_count}), 64'(0));
        exp_q.push_back(ew(4'd5, 4'd0, 4'd0, 4'd1, 1'b0, 16'd1));
        cycles(3);
        check("midrst_no_early", 64'(inst_count), 64'(0));
        cycles(1);
        check("midrst_commit", 64'(inst_count), 64'(1));
        run = 1'b0;

        // Saturating 2-bit counter, DIV=1 ticks every cycle, no halt detection.
        run_sat = 1'b1;
        cycles(2);
        check("sat_count_2", 64'(inst_count_sat), 64'(2));
        cycles(3);
        check("sat_count_5", 64'({current_sat.pc, inst_count_sat}), 64'({4'd5, 2'd3}));
        cycles(2);
        check("sat_selfloop", 64'({halted_sat, commit_sat, current_sat.pc, inst_count_sat}),
              64'({1'b0, 1'b1, 4'd5, 2'd3}));
        run_sat = 1'b0;
        cycles(3);
        check("sat_hold", 64'({commit_sat, inst_count_sat}), 64'({1'b0, 2'd3}));
        check("final_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
